// File: rtl/soc_status_collector.sv
// Builds the 32-bit coprocessor status word for the HPS status PIO: lifecycle state,
// sticky done/error/timeout flags, a wrapping done counter and a busy watchdog.
module soc_status_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000,
  parameter logic [3:0]  TIMEOUT_CODE   = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start_pulse,
  input  logic [7:0]  i_opcode,
  input  logic        i_done_pulse,
  input  logic        i_err_pulse,
  input  logic [3:0]  i_err_code,
  input  logic        i_ack_toggle,
  output logic [31:0] o_status_word,
  output logic        o_abort_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_timeout;
  logic [3:0]  r_code;
  logic [7:0]  r_doneCount;
  logic [7:0]  r_opcode;
  logic [31:0] r_timer;
  logic        r_ackQ;
  logic        r_ackValid;
  logic        r_abort;

  logic        w_ackEdge;
  logic        w_timeout;

  // r_ackValid masks the bogus edge seen on the first clock after reset release
  assign w_ackEdge = r_ackValid & (i_ack_toggle ^ r_ackQ);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_code      <= 4'd0;
      r_doneCount <= 8'd0;
      r_opcode    <= 8'd0;
      r_timer     <= 32'd0;
      r_ackQ      <= 1'b0;
      r_ackValid  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_ackQ     <= i_ack_toggle;
      r_ackValid <= 1'b1;
      r_abort    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_pulse) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_opcode <= i_opcode;
            r_timer  <= 32'd0;
          end
        end
        S_RUN: begin
          // Timer saturates at the expiry value and is frozen when the watchdog is disabled
          if ((TIMEOUT_CYCLES != 0) && !w_timeout) begin
            r_timer <= r_timer + 32'd1;
          end
          if (i_err_pulse) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_code  <= i_err_code;
          end else if (i_done_pulse) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_doneCount <= r_doneCount + 8'd1;
          end else if (w_timeout) begin
            r_state   <= S_ERR;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
            r_timeout <= 1'b1;
            r_code    <= TIMEOUT_CODE;
            r_abort   <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (w_ackEdge) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_code    <= 4'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_status_word = {r_ackQ, 7'd0, r_opcode, r_doneCount, r_code,
                          r_timeout, r_error, r_done, r_busy};
  assign o_abort_pulse = r_abort;

endmodule

// File: tb/tb_soc_status_collector.sv
// Self-checking bench for soc_status_collector: directed vector table, hand-written
// corner-case sequences and randomized traffic against a lifecycle-level reference model.
module tb_soc_status_collector;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op = 8'd0;
  logic        done = 1'b0;
  logic        err = 1'b0;
  logic [3:0]  code = 4'd0;
  logic        ack = 1'b0;
  logic [31:0] word;
  logic        abortP;

  int errors = 0;
  int checks = 0;

  soc_status_collector #(.TIMEOUT_CYCLES(TO), .TIMEOUT_CODE(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .i_start_pulse(start), .i_opcode(op),
    .i_done_pulse(done), .i_err_pulse(err), .i_err_code(code), .i_ack_toggle(ack),
    .o_status_word(word), .o_abort_pulse(abortP)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = no operation, 1 = operation in flight, 2 = finished, awaiting ack
  int       mPhase;
  int       mRunCycles;
  int       mCount;
  bit       mDoneF, mErrF, mToF, mAckQ, mAckSeen, mAbort;
  bit [3:0] mCode;
  bit [7:0] mOp;

  function automatic logic [31:0] modelWord();
    return {mAckQ, 7'd0, mOp, 8'(mCount), mCode, mToF, mErrF, mDoneF, (mPhase == 1)};
  endfunction

  task automatic modelReset();
    mPhase = 0; mRunCycles = 0; mCount = 0;
    mDoneF = 0; mErrF = 0; mToF = 0; mAckQ = 0; mAckSeen = 0; mAbort = 0;
    mCode = 0; mOp = 0;
  endtask

  task automatic modelStep(input bit s, input bit [7:0] o, input bit d, input bit e,
                           input bit [3:0] c, input bit a);
    bit ackChanged;
    ackChanged = mAckSeen && (a != mAckQ);
    mAbort = 0;
    if (mPhase == 0) begin
      if (s) begin mPhase = 1; mOp = o; mRunCycles = 0; end
    end else if (mPhase == 1) begin
      if (e) begin
        mPhase = 2; mErrF = 1; mCode = c;
      end else if (d) begin
        mPhase = 2; mDoneF = 1; mCount = (mCount + 1) % 256;
      end else if (mRunCycles == TO - 1) begin
        mPhase = 2; mErrF = 1; mToF = 1; mCode = 4'hF; mAbort = 1;
      end
      mRunCycles++;
    end else if (ackChanged) begin
      mPhase = 0; mDoneF = 0; mErrF = 0; mToF = 0; mCode = 0;
    end
    mAckQ = a;
    mAckSeen = 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model, and compares after the edge
  task automatic applyStimulus(input bit s, input bit [7:0] o, input bit d, input bit e,
                               input bit [3:0] c, input bit a, input string name);
    start = s; op = o; done = d; err = e; code = c; ack = a;
    modelStep(s, o, d, e, c, a);
    @(posedge clk);
    #1;
    checkOutput({name, ".word"}, word, modelWord());
    checkOutput({name, ".abort"}, {31'd0, abortP}, {31'd0, mAbort});
  endtask

  task automatic doReset();
    reset_n = 0; start = 0; op = 0; done = 0; err = 0; code = 0; ack = 0;
    modelReset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset.word", word, 32'h0);
    checkOutput("reset.abort", {31'd0, abortP}, 32'h0);
    reset_n = 1;
  endtask

  typedef struct {
    bit          s;
    bit [7:0]    o;
    bit          d;
    bit          e;
    bit [3:0]    c;
    bit          a;
    int          rep;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit curAck;

    vecs[0] = '{1, 8'h3A, 0, 0, 4'h0, 0, 1, 32'h003A0001};
    vecs[1] = '{0, 8'h00, 0, 0, 4'h0, 0, 9, 32'h003A0001};
    vecs[2] = '{0, 8'h00, 1, 0, 4'h0, 0, 1, 32'h003A0102};
    vecs[3] = '{0, 8'h00, 0, 0, 4'h0, 1, 1, 32'h803A0100};
    vecs[4] = '{1, 8'h05, 0, 0, 4'h0, 1, 1, 32'h80050101};
    vecs[5] = '{0, 8'h00, 0, 1, 4'h6, 1, 1, 32'h80050164};
    vecs[6] = '{0, 8'h00, 0, 0, 4'h0, 0, 1, 32'h00050100};
    vecs[7] = '{0, 8'h00, 0, 0, 4'h0, 1, 1, 32'h80050100};
    vecs[8] = '{0, 8'h00, 1, 0, 4'h0, 1, 1, 32'h80050100};
    vecs[9] = '{0, 8'h00, 0, 1, 4'h9, 1, 1, 32'h80050100};

    doReset();

    // Normal completion, error path, and ack/done/err behaviour while idle
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        applyStimulus(vecs[i].s, vecs[i].o, vecs[i].d, vecs[i].e, vecs[i].c, vecs[i].a, "table");
        checkOutput($sformatf("table[%0d]", i), word, vecs[i].expWord);
      end
    end

    // Watchdog: abort exactly 16 cycles after the start cycle
    applyStimulus(1, 8'h11, 0, 0, 4'h0, 1, "wdog.start");
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(0, 8'h00, 0, 0, 4'h0, 1, "wdog.hold");
      checkOutput($sformatf("wdog.abort@%0d", k), {31'd0, abortP}, {31'd0, (k == 16)});
    end
    checkOutput("wdog.lowbyte", {24'd0, word[7:0]}, 32'h000000FC);
    checkOutput("wdog.word", word, 32'h801101FC);
    applyStimulus(0, 8'h00, 0, 0, 4'h0, 0, "wdog.ack");
    checkOutput("wdog.cleared", word, 32'h00110100);

    // Collision: err wins, count unchanged; start ignored in ERR and on the ack cycle
    applyStimulus(1, 8'h22, 0, 0, 4'h0, 0, "coll.start");
    applyStimulus(0, 8'h00, 0, 0, 4'h0, 0, "coll.run");
    applyStimulus(0, 8'h00, 1, 1, 4'h3, 0, "coll.both");
    checkOutput("coll.err", word, 32'h00220134);
    applyStimulus(1, 8'h77, 0, 0, 4'h0, 0, "coll.startInErr");
    checkOutput("coll.ignored", word, 32'h00220134);
    applyStimulus(1, 8'h88, 0, 0, 4'h0, 1, "coll.ackStart");
    checkOutput("coll.ackStart", word, 32'h80220100);
    applyStimulus(0, 8'h00, 0, 0, 4'h0, 1, "coll.after");
    checkOutput("coll.stillIdle", word, 32'h80220100);

    // Wrap: 256 complete operations bring the done counter back to zero
    doReset();
    curAck = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 8'(i), 0, 0, 4'h0, curAck, "wrap.start");
      applyStimulus(0, 8'h00, 1, 0, 4'h0, curAck, "wrap.done");
      curAck = ~curAck;
      applyStimulus(0, 8'h00, 0, 0, 4'h0, curAck, "wrap.ack");
    end
    checkOutput("wrap.count", {24'd0, word[15:8]}, 32'h0);
    checkOutput("wrap.word", word, 32'h00FF0000);
    applyStimulus(0, 8'h00, 0, 0, 4'h0, 1, "wrap.idleAck");
    checkOutput("wrap.idleAck", word, 32'h80FF0000);

    // Asynchronous reset in the middle of an operation
    doReset();
    applyStimulus(1, 8'h5A, 0, 0, 4'h0, 0, "rst.start");
    for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 0, 0, 4'h0, 0, "rst.run");
    checkOutput("rst.busy", word, 32'h005A0001);
    #2 reset_n = 0;
    #1 checkOutput("rst.async", word, 32'h0);
    modelReset();
    @(posedge clk); #1;
    checkOutput("rst.edge", word, 32'h0);
    checkOutput("rst.abort", {31'd0, abortP}, 32'h0);
    reset_n = 1;
    for (int k = 0; k < 20; k++) applyStimulus(0, 8'h00, 0, 0, 4'h0, 0, "rst.quiet");

    // Randomized traffic against the reference model
    doReset();
    curAck = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) curAck = ~curAck;
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 11) == 0,
                    $urandom_range(0, 19) == 0, 4'($urandom), curAck, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
